// File: rtl/resp_misr_checker.sv
// resp_misr_checker: compresses a DUT output bus into a MISR signature over a
// fixed number of qualified samples, then compares it against a golden value
// and holds a pass/fail verdict until the next start or reset.
module resp_misr_checker #(
    parameter int unsigned      DATA_W      = 192,
    parameter int unsigned      SIG_W       = 32,
    parameter logic [SIG_W-1:0] POLY        = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED        = 32'hFFFFFFFF,
    parameter int unsigned      NUM_SAMPLES = 21,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] y_in,
    input  logic [SIG_W-1:0]  expected_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [SIG_W-1:0]  signature,
    output logic [CNT_W-1:0]  sample_count
);

    localparam int unsigned      NSLICE   = DATA_W / SIG_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [SIG_W-1:0]   sig_q, sig_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               pass_q, pass_n;
    logic               fail_q, fail_n;
    logic               busy_q, done_q;

    logic [SIG_W-1:0]   fold_c;
    logic [SIG_W-1:0]   step_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               match_c;

    // XOR-fold the wide output bus down to one signature-width word
    always_comb begin
        fold_c = '0;
        for (int k = 0; k < int'(NSLICE); k++) begin
            fold_c = fold_c ^ y_in[k*SIG_W +: SIG_W];
        end
    end

    // One MISR shift with polynomial feedback plus the folded sample
    always_comb begin
        step_c = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : '0)
               ^ fold_c;
    end

    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign match_c   = (sig_q == expected_sig);

    // State register and registered datapath; outputs derive from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            sig_q   <= sig_n;
            cnt_q   <= cnt_n;
            pass_q  <= pass_n;
            fail_q  <= fail_n;
            busy_q  <= (state_n == ST_RUN) || (state_n == ST_CHECK);
            done_q  <= (state_n == ST_DONE);
        end
    end

    // Next-state, signature, counter and verdict selection
    always_comb begin
        state_n = state_q;
        sig_n   = sig_q;
        cnt_n   = cnt_q;
        pass_n  = 1'b0;
        fail_n  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    sig_n   = SEED;
                    cnt_n   = '0;
                end
            end

            ST_RUN: begin
                // A start here aborts the run; the concurrent sample is dropped
                if (start) begin
                    sig_n = SEED;
                    cnt_n = '0;
                end else if (sample_valid) begin
                    sig_n = step_c;
                    cnt_n = cnt_inc_c;
                    if (cnt_inc_c == LAST_CNT) begin
                        state_n = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (start) begin
                    state_n = ST_RUN;
                    sig_n   = SEED;
                    cnt_n   = '0;
                end else begin
                    state_n = ST_DONE;
                    pass_n  = match_c;
                    fail_n  = ~match_c;
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_n = ST_RUN;
                    sig_n   = SEED;
                    cnt_n   = '0;
                end else begin
                    pass_n = pass_q;
                    fail_n = fail_q;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign signature    = sig_q;
    assign sample_count = cnt_q;

endmodule
